cache_assoc_wb_param: RTL

//  Parametrised N-way set-associative, write-back/write-allocate cache level with true-LRU replacement.

---
 rtl/cache_assoc_wb_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_assoc_wb_param.sv
// N-way set-associative write-back/write-allocate cache with true-LRU replacement, one word per line.
// Optional CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module cache_assoc_wb_param #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16,
   parameter int SETS   = 2,
   parameter int WAYS   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] read_data,
   output logic              ready,
   output logic              busy,
   output logic              hit,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count,
   output logic [15:0]       wb_count
`endif
);

   localparam int SET_BITS = $clog2(SETS);
   localparam int TAG_W    = ADDR_W - SET_BITS;
   localparam int AGE_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_WB     = 3'd2,
      ST_FILL   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                is_write_r;
   logic                hit_r;
   logic [AGE_W-1:0]    way_r;

   logic [WAYS-1:0]     valid_r [SETS];
   logic [WAYS-1:0]     dirty_r [SETS];
   logic [TAG_W-1:0]    tag_r   [SETS][WAYS];
   logic [DATA_W-1:0]   data_r  [SETS][WAYS];
   ages_t               age_r   [SETS];

   logic [SET_BITS-1:0] index_s;
   logic [TAG_W-1:0]    tag_s;
   logic                hit_s;
   logic [AGE_W-1:0]    hit_way_s;
   logic [AGE_W-1:0]    victim_s;
   logic                victim_dirty_s;

   // Accessed way becomes youngest; only ways younger than its old age get older.
   function automatic ages_t lru_update(input ages_t ages, input logic [AGE_W-1:0] way);
      ages_t res;
      res = ages;
      for (int i = 0; i < WAYS; i++) begin
         if (i == int'(way)) begin
            res[i] = {AGE_W{1'b0}};
         end else if (ages[i] < ages[way]) begin
            res[i] = ages[i] + 1'b1;
         end else begin
            res[i] = ages[i];
         end
      end
      return res;
   endfunction

   assign index_s = addr_r[SET_BITS-1:0];
   assign tag_s   = addr_r[ADDR_W-1:SET_BITS];

   // Tag match across the set and victim choice (lowest invalid way beats the oldest way).
   always_comb begin
      hit_s     = 1'b0;
      hit_way_s = {AGE_W{1'b0}};
      victim_s  = {AGE_W{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         victim_s = (age_r[index_s][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : victim_s;
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_s     = (valid_r[index_s][w] && tag_r[index_s][w] == tag_s) ? 1'b1 : hit_s;
         hit_way_s = (valid_r[index_s][w] && tag_r[index_s][w] == tag_s) ? AGE_W'(w) : hit_way_s;
         victim_s  = (!valid_r[index_s][w]) ? AGE_W'(w) : victim_s;
      end
      victim_dirty_s = valid_r[index_s][victim_s] & dirty_r[index_s][victim_s];
   end

   // Request FSM, tag/data/LRU state and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         addr_r         <= {ADDR_W{1'b0}};
         wdata_r        <= {DATA_W{1'b0}};
         is_write_r     <= 1'b0;
         hit_r          <= 1'b0;
         way_r          <= {AGE_W{1'b0}};
         read_data      <= {DATA_W{1'b0}};
         ready          <= 1'b0;
         busy           <= 1'b0;
         hit            <= 1'b0;
         mem_address    <= {ADDR_W{1'b0}};
         mem_write_data <= {DATA_W{1'b0}};
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= {WAYS{1'b0}};
            dirty_r[s] <= {WAYS{1'b0}};
            for (int w = 0; w < WAYS; w++) begin
               age_r[s][w] <= AGE_W'(w);
            end
         end
      end else begin
         ready <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if ((read || write) && !busy) begin
                  addr_r     <= address;
                  wdata_r    <= write_data;
                  is_write_r <= write;
                  busy       <= 1'b1;
                  state_r    <= ST_LOOKUP;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_LOOKUP: begin
               if (hit_s) begin
                  hit_r          <= 1'b1;
                  way_r          <= hit_way_s;
                  age_r[index_s] <= lru_update(age_r[index_s], hit_way_s);
                  if (is_write_r) begin
                     data_r[index_s][hit_way_s]  <= wdata_r;
                     dirty_r[index_s][hit_way_s] <= 1'b1;
                  end
                  state_r <= ST_RESP;
               end else begin
                  hit_r <= 1'b0;
                  way_r <= victim_s;
                  if (victim_dirty_s) begin
                     mem_write      <= 1'b1;
                     mem_address    <= {tag_r[index_s][victim_s], index_s};
                     mem_write_data <= data_r[index_s][victim_s];
                     state_r        <= ST_WB;
                  end else begin
                     mem_read    <= 1'b1;
                     mem_address <= addr_r;
                     state_r     <= ST_FILL;
                  end
               end
            end
            ST_WB: begin
               if (mem_ready) begin
                  mem_write   <= 1'b0;
                  mem_read    <= 1'b1;
                  mem_address <= addr_r;
                  state_r     <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (mem_ready) begin
                  mem_read                <= 1'b0;
                  tag_r[index_s][way_r]   <= tag_s;
                  valid_r[index_s][way_r] <= 1'b1;
                  data_r[index_s][way_r]  <= is_write_r ? wdata_r : mem_read_data;
                  dirty_r[index_s][way_r] <= is_write_r;
                  age_r[index_s]          <= lru_update(age_r[index_s], way_r);
                  state_r                 <= ST_RESP;
               end
            end
            ST_RESP: begin
               ready     <= 1'b1;
               hit       <= hit_r;
               read_data <= data_r[index_s][way_r];
               state_r   <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // Saturating event counters: responses by outcome, and completed write-backs.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_count  <= 16'd0;
         miss_count <= 16'd0;
         wb_count   <= 16'd0;
      end else begin
         if (state_r == ST_RESP && hit_r && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (state_r == ST_RESP && !hit_r && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
         if (state_r == ST_WB && mem_ready && wb_count != 16'hFFFF) begin
            wb_count <= wb_count + 16'd1;
         end
      end
   end
`endif

endmodule
